mod_src_arbiter: RTL and testbench

- Round-robin arbiter sharing one symbol path into the modulator among N_REQ sources.
- Drives the select of the shared N:1 data mux and the valid/ready handshakes on both sides.
- A grant is held for one burst: until a transfer with `last` set, or until MAX_BURST transfers, whichever comes first.
- Sits between the symbol sources (mapper, pilot inserter, preamble ROM, test pattern) and the modulator input.

---
 rtl/mod_src_arbiter.sv | 101 ++++++++++
 tb/tb_mod_src_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod_src_arbiter.sv
// Round-robin arbiter sharing one symbol path into the modulator among N_REQ sources.
// A grant is held for one burst: until a transfer with last, or MAX_BURST transfers.
module mod_src_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    parameter int SW        = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_last,
    input  logic                   out_ready,
    output logic [SW-1:0]          out_src,
    output logic                   busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    state_t           state;
    logic [SW-1:0]    rr_ptr;
    logic [7:0]       burst_cnt;
    logic [SW-1:0]    grant_c;
    logic [SW-1:0]    idx_c;
    logic             found_c;
    logic             xfer_c;
    logic [WIDTH-1:0] data_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Round-robin search from rr_ptr; iterating downwards lets the lowest offset win.
    always_comb begin
        found_c = 1'b0;
        grant_c = '0;
        idx_c   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx_c = SW'((int'(rr_ptr) + i) % N_REQ);
            if (req_valid[idx_c]) begin
                found_c = 1'b1;
                grant_c = idx_c;
            end
        end
    end

    // Shared path is steered straight through the mux while a grant is held.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state == GRANT) begin
            out_valid          = req_valid[out_src];
            out_data           = data_arr[out_src];
            out_last           = req_last[out_src] | (burst_cnt == LAST_CNT);
            req_ready[out_src] = out_ready;
        end
    end

    assign xfer_c = out_valid & out_ready;
    assign busy   = (state == GRANT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_src   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found_c) begin
                        state     <= GRANT;
                        out_src   <= grant_c;
                        burst_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (xfer_c) begin
                        if (out_last) begin
                            state  <= IDLE;
                            rr_ptr <= SW'((int'(out_src) + 1) % N_REQ);
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_src_arbiter.sv
// Testbench for mod_src_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level model of the round-robin burst rules.
module tb_mod_src_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [SW-1:0]  out_src;
    logic           busy;

    mod_src_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB), .SW(SW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .out_src(out_src), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SW-1:0] src;
        logic [W-1:0]  d;
        logic          l;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    int   n_xfer = 0;
    int   n_maxhit = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every DUT transfer pops the oldest predicted transfer.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            exp_t e;
            n_xfer++;
            if (q.size() == 0) begin
                check("unexpected_xfer", 32'(out_src), 32'hFFFF);
            end else begin
                e = q.pop_front();
                check("xfer_src", 32'(out_src), 32'(e.src));
                check("xfer_data", 32'(out_data), 32'(e.d));
                check("xfer_last", 32'(out_last), 32'(e.l));
                check("xfer_ready", 32'(req_ready), 32'(1 << e.src));
                check("xfer_busy", 32'(busy), 32'd1);
            end
        end
    end

    task automatic set_src(input int i, input logic v, input logic [W-1:0] d, input logic l);
        req_valid[i]         = v;
        req_data[i*W +: W]   = d;
        req_last[i]          = l;
    endtask

    // Model state: owner (-1 = nobody), transfers in burst, search start.
    int           m_own;
    int           m_cnt;
    int           m_ptr;
    logic [W-1:0] hd [N];
    logic         hl [N];
    int           last_pct;

    task automatic new_head(input int i);
        hd[i] = W'($urandom);
        hl[i] = ($urandom_range(0, 99) < last_pct);
    endtask

    task automatic model_step(input logic [N-1:0] v, input logic rdy);
        exp_t e;
        logic lst;
        bit   found;
        if (m_own < 0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && v[(m_ptr + k) % N]) begin
                    found = 1'b1;
                    m_own = (m_ptr + k) % N;
                    m_cnt = 0;
                end
            end
        end else if (v[m_own] && rdy) begin
            lst   = hl[m_own] || (m_cnt == MB - 1);
            if (!hl[m_own] && m_cnt == MB - 1) n_maxhit++;
            e.src = SW'(m_own);
            e.d   = hd[m_own];
            e.l   = lst;
            q.push_back(e);
            new_head(m_own);
            if (lst) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end else begin
                m_cnt++;
            end
        end
    endtask

    initial begin
        logic [N-1:0] v;
        logic         rdy;
        int           vpct;

        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_last", 32'(out_last), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_out_src", 32'(out_src), 0);
        check("rst_out_data", 32'(out_data), 0);
        rst = 1'b0;

        // Single source 2, one-symbol burst.
        @(posedge clk); #1;
        set_src(2, 1'b1, 8'h5A, 1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        check("c0_busy", 32'(busy), 0);
        check("c0_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("c1_busy", 32'(busy), 1);
        check("c1_out_src", 32'(out_src), 2);
        check("c1_out_valid", 32'(out_valid), 1);
        check("c1_out_data", 32'(out_data), 32'h5A);
        check("c1_req_ready", 32'(req_ready), 32'b0100);
        check("c1_out_last", 32'(out_last), 1);
        @(posedge clk); #1;
        set_src(0, 1'b1, 8'h11, 1'b1);
        set_src(2, 1'b1, 8'h22, 1'b1);
        @(negedge clk);
        check("c2_busy", 32'(busy), 0);
        check("c2_out_src_hold", 32'(out_src), 2);
        @(negedge clk);
        check("c3_wrap_src", 32'(out_src), 0);
        check("c3_out_data", 32'(out_data), 32'h11);
        @(negedge clk);
        check("c4_bubble", 32'(busy), 0);
        @(negedge clk);
        check("c5_src", 32'(out_src), 2);
        @(posedge clk); #1;
        req_valid = '0; req_last = '0;
        @(posedge clk); #1;

        // Async reset during the 5th transfer of a source-1 burst.
        set_src(1, 1'b1, 8'h33, 1'b0);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        check("ar_busy_before", 32'(busy), 1);
        check("ar_src_before", 32'(out_src), 1);
        #1 rst = 1'b1;
        #1;
        check("ar_busy", 32'(busy), 0);
        check("ar_out_valid", 32'(out_valid), 0);
        check("ar_req_ready", 32'(req_ready), 0);
        check("ar_out_src", 32'(out_src), 0);
        check("ar_out_data", 32'(out_data), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0; req_last = '0;
        set_src(2, 1'b1, 8'h44, 1'b0);
        set_src(3, 1'b1, 8'h55, 1'b0);
        @(negedge clk);
        check("ar_idle_after", 32'(busy), 0);
        @(negedge clk);
        check("ar_regrant_src", 32'(out_src), 2);
        check("ar_regrant_busy", 32'(busy), 1);

        // Randomized run against the model.
        rst = 1'b1; req_valid = '0; req_last = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        m_own = -1; m_cnt = 0; m_ptr = 0;
        last_pct = 25;
        for (int i = 0; i < N; i++) new_head(i);
        mon_en = 1'b1;
        for (int it = 0; it < 3000; it++) begin
            @(posedge clk); #1;
            if (it < 1000)      begin last_pct = 25; vpct = 70;  end
            else if (it < 2000) begin last_pct = 0;  vpct = 100; end
            else                begin last_pct = 50; vpct = 85;  end
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 99) < vpct);
                set_src(i, v[i], hd[i], hl[i]);
            end
            rdy = (it >= 1000 && it < 2000) ? 1'b1 : ($urandom_range(0, 99) < 75);
            out_ready = rdy;
            model_step(v, rdy);
        end
        @(negedge clk);
        mon_en = 1'b0;
        check("queue_drained", 32'(q.size()), 0);
        if (n_maxhit == 0 || n_xfer < 500)
            check("coverage_xfers", 32'(n_maxhit > 0 && n_xfer >= 500), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
